// File: rtl/display_sequencer.sv
// display_sequencer: drives the four seven-segment digit codes for score, clear and blinking FAIL.
// Optional leading-zero blanking of the tens digit is enabled by defining DISP_BLANK_LZ_EN.
module display_sequencer #(
    parameter int BLINK_DIV   = 25000000,
    parameter int BLINK_COUNT = 3,
    parameter int SCORE_W     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [SCORE_W-1:0] cmd_score,
    output logic               busy,
    output logic               done,
    output logic [3:0]         digit3,
    output logic [3:0]         digit2,
    output logic [3:0]         digit1,
    output logic [3:0]         digit0
);
    typedef enum logic [1:0] {IDLE, CONVERT, BLINK, FINISH} state_t;

    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int BW = $clog2(BLINK_COUNT + 1);
    localparam logic [PW-1:0] PH_MAX  = PW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BLINK_COUNT - 1);
    localparam logic [1:0]  OP_CLEAR = 2'b00;
    localparam logic [1:0]  OP_SCORE = 2'b01;
    localparam logic [1:0]  OP_FAIL  = 2'b10;
    localparam logic [3:0]  BLANK    = 4'hF;
    localparam logic [15:0] ALL_OFF  = 16'hFFFF;
    localparam logic [15:0] FAIL_MSG = 16'hABCD;

    state_t        state;
    logic [15:0]   digits;
    logic [6:0]    rem;
    logic [3:0]    tens;
    logic [3:0]    tens_code;
    logic [PW-1:0] phase;
    logic [BW-1:0] pairs;
    logic          lit;
    logic [31:0]   score_ext;

    assign score_ext = 32'(cmd_score);
    assign cmd_ready = (state == IDLE) && !done;
    assign {digit3, digit2, digit1, digit0} = digits;

`ifdef DISP_BLANK_LZ_EN
    assign tens_code = (tens == 4'd0) ? BLANK : tens;
`else
    assign tens_code = tens;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            digits <= ALL_OFF;
            rem    <= '0;
            tens   <= '0;
            phase  <= '0;
            pairs  <= '0;
            lit    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        case (cmd_op)
                            OP_CLEAR: begin
                                digits <= ALL_OFF;
                                done   <= 1'b1;
                                state  <= FINISH;
                            end
                            OP_SCORE: begin
                                rem   <= (score_ext > 32'd99) ? 7'd99 : score_ext[6:0];
                                tens  <= '0;
                                busy  <= 1'b1;
                                state <= CONVERT;
                            end
                            OP_FAIL: begin
                                digits <= FAIL_MSG;
                                phase  <= '0;
                                pairs  <= '0;
                                lit    <= 1'b1;
                                busy   <= 1'b1;
                                state  <= BLINK;
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        endcase
                    end
                end
                // Repeated subtraction: one tens step per cycle, saturation bounds it to 9 steps.
                CONVERT: begin
                    if (rem >= 7'd10) begin
                        rem  <= rem - 7'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        digits <= {BLANK, BLANK, tens_code, rem[3:0]};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= FINISH;
                    end
                end
                BLINK: begin
                    if (phase == PH_MAX) begin
                        phase  <= '0;
                        lit    <= !lit;
                        digits <= lit ? ALL_OFF : FAIL_MSG;
                        if (!lit) begin
                            pairs <= pairs + 1'b1;
                            if (pairs == BC_LAST) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: scoreboard bench; driver queues expected digits/latency, monitor checks on done.
module tb_display_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_score;
    logic       busy;
    logic       done;
    logic [3:0] digit3, digit2, digit1, digit0;

    typedef struct {
        logic [15:0] dig;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    logic prev_done = 1'b0;

`ifdef DISP_BLANK_LZ_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    display_sequencer #(.BLINK_DIV(4), .BLINK_COUNT(2), .SCORE_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_score(cmd_score), .busy(busy), .done(done),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Edge counter and acceptance timestamp (edge numbers are 1-based).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) acc_edge <= cyc + 1;
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_single", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending command");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digits", {16'd0, digit3, digit2, digit1, digit0}, {16'd0, e.dig});
                chk("latency", cyc - acc_edge, e.lat);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        prev_done = done;
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [6:0] score,
                         input logic [15:0] dig, input int lat, input bit push);
        int n = 0;
        if (push) sb.push_back('{dig: dig, lat: lat});
        cmd_op = op;
        cmd_score = score;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(n), 32'd0);
        chk("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_score = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 7'd42, 16'hFF42, 5, 1);
        chk("busy_convert", 32'(busy), 32'd1);
        drain();
        issue(2'b01, 7'd120, 16'hFF99, 10, 1);
        drain();
        issue(2'b01, 7'd5, {8'hFF, LZ, 4'h5}, 1, 1);
        drain();
        issue(2'b01, 7'd0, {8'hFF, LZ, 4'h0}, 1, 1);
        drain();
        issue(2'b01, 7'd10, 16'hFF10, 2, 1);
        drain();
        issue(2'b01, 7'd9, {8'hFF, LZ, 4'h9}, 1, 1);
        drain();
        issue(2'b11, 7'd0, {8'hFF, LZ, 4'h9}, 0, 1);
        drain();
        issue(2'b00, 7'd0, 16'hFFFF, 0, 1);
        drain();

        issue(2'b10, 7'd0, 16'hABCD, 16, 1);
        chk("blink_p1", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000ABCD);
        chk("busy_blink", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        chk("blink_p5", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        repeat (4) @(negedge clk);
        chk("blink_p9", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000ABCD);
        repeat (4) @(negedge clk);
        chk("blink_p13", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        repeat (3) @(negedge clk);
        chk("blink_p16", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        @(negedge clk);
        chk("blink_p17", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000ABCD);
        drain();
        repeat (5) @(negedge clk);
        chk("fail_persist", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000ABCD);

        issue(2'b10, 7'd0, 16'hABCD, 16, 1);
        issue(2'b00, 7'd0, 16'hFFFF, 0, 1);
        drain();
        chk("clear_after_hold", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);

        issue(2'b10, 7'd0, 16'h0000, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_digits_hold", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Sequences the four seven-segment digit decoders of the Simon-says board.
- Accepts commands from the game FSM: clear, show score, show the blinking "FAIL" message.
- Converts the binary score to two BCD digits over several cycles.
- Drives 4-bit display codes per digit; the decoders map 0x0-0x9 to numerals, 0xA/0xB/0xC/0xD to F/A/I/L, and 0xF to blank.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period (on or off phase); minimum 1.
- BLINK_COUNT, 3, number of off/on blink pairs before "FAIL" is held steady; minimum 1.
- SCORE_W, 7, width of the cmd_score input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when a command can be accepted.
- cmd_op  input  2  00 CLEAR, 01 SHOW_SCORE, 10 SHOW_FAIL, 11 reserved.
- cmd_score  input  SCORE_W  binary score; sampled with SHOW_SCORE.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle pulse when a command completes.
- digit3  output  4  display code, leftmost digit.
- digit2  output  4  display code.
- digit1  output  4  display code, tens.
- digit0  output  4  display code, ones / rightmost.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, digit3..digit0=4'hF (blank), all counters 0.
- Reset asserted mid-operation aborts the command at the next edge with the same values.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) && !done.
  - Commands presented while not ready are ignored and must be held by the requester.
  - cmd_op and cmd_score are captured on acceptance.
- States: IDLE, CONVERT, BLINK, FINISH.
- IDLE: digits hold their last values.
- On acceptance:
  - CLEAR: all digits set to 4'hF on the next edge, go to FINISH.
  - SHOW_SCORE: remainder <= min(cmd_score, 99) (saturate), tens <= 0, go to CONVERT.
  - SHOW_FAIL: digits <= {A, b, C, d} next edge, phase counter 0, blink counter 0, go to BLINK.
  - 11: no digit change, go to FINISH.
- CONVERT: each cycle, if remainder >= 10 then remainder -= 10 and tens += 1; otherwise write digit3=F, digit2=F, digit1=tens, digit0=remainder and go to FINISH.
  - Latency from acceptance to digits valid: floor(s/10)+2 edges, where s is the saturated score.
  - Worst case s=99: 11 edges.
- BLINK:
  - Phase counter counts 0..BLINK_DIV-1; on wrap the displayed digits toggle between {A, b, C, d} and all-F.
  - A blink pair completes on each return to "on".
  - After BLINK_COUNT pairs, with the digits showing "FAIL", go to FINISH.
  - Total time from acceptance to FINISH entry: 1 + 2*BLINK_COUNT*BLINK_DIV edges.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE; cmd_ready rises the following cycle.
- busy = 1 in CONVERT and BLINK, and for the FINISH cycle's predecessor; it is 0 in IDLE and FINISH.
- Back-to-back commands: minimum spacing is acceptance → FINISH → IDLE. No command overlaps; displayed digits persist until the next command's first write.
- Arithmetic: tens is 4 bits; remainder is 7 bits. Saturation makes tens ≤ 9 and remainder ≤ 9 at the end of conversion.

Optional Feature:
- Macro DISP_BLANK_LZ_EN (leading-zero blanking).
- Defined: if tens==0 at the end of CONVERT, digit1=4'hF (blank); a score of 7 shows as " 7", and 0 shows as " 0".
- Undefined: digit1 always shows tens; a score of 7 shows as "07".
- No effect on CLEAR or FAIL.

Test Plan:
- Reset with rst_n=0 for 2 cycles → digits all 4'hF, cmd_ready=1, busy=0, done=0.
- SHOW_SCORE with cmd_score=42 → after 6 edges digit1=4, digit0=2, digit3=digit2=F; done pulses once; cmd_ready returns 1.
- SHOW_SCORE with cmd_score=120 (saturation) → digit1=9, digit0=9 at 11 edges. Score 5 → digit1=F with DISP_BLANK_LZ_EN defined, 0 without.
- BLINK_DIV=4, BLINK_COUNT=2, SHOW_FAIL:
  - digits=A,b,C,d at +1.
  - All F at +5, FAIL at +9, F at +13, FAIL at +17.
  - done at FINISH; FAIL remains displayed afterward.
- Handshake: hold cmd_valid with CLEAR during a SHOW_FAIL → not accepted until cmd_ready=1, then digits blank and done pulses once.
- rst_n=0 asserted mid-BLINK → next edge: digits all F, state IDLE, no done pulse.
